// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_ctrl
// Purpose  : Hazard detection and stall/flush sequencer for a 5-stage MIPS
//            pipeline with branches resolved in ID. Catches the hazards that
//            forwarding cannot cover (load-use, branch operands produced by
//            the instructions just ahead), drives PC / IF-ID write enables and
//            IF-ID / ID-EX flushes, and runs a debug-halt drain handshake.
// Ports    : clk, rst_n (async, active low)
//            id_*            : decoded fields of the instruction in ID
//            branch_taken    : ID branch comparison result
//            ex_*            : ID/EX MemRead, RegWrite and destination
//            mem_*           : EX/MEM MemRead and destination
//            halt_req        : level debug halt request
//            pc_write, ifid_write, ifid_flush, idex_flush : pipeline control
//            stall_cause     : 00 none, 01 load-use, 10 branch-after-ALU,
//                              11 branch-after-load
//            halt_ack        : registered, pipeline halted and drained
//            stall_count     : only with HAZ_STALL_CNT_EN, saturating count of
//                              hazard stall cycles
// Options  : define HAZ_STALL_CNT_EN to add the stall_count output/counter.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl #(
  parameter int HALT_DRAIN = 3,   // 1..7 bubble cycles before halt_ack
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_branch,
  input  logic             id_jump,
  input  logic             branch_taken,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [4:0]       ex_rd,
  input  logic             mem_mem_read,
  input  logic [4:0]       mem_rd,
  input  logic             halt_req,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       stall_cause,
  output logic             halt_ack
`ifdef HAZ_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_count
`endif
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  localparam logic [2:0] DRAIN_N    = 3'(HALT_DRAIN);
  localparam logic [2:0] DRAIN_LAST = 3'(HALT_DRAIN - 1);

  state_t     state;
  logic [1:0] stall_cnt;
  logic [2:0] drain_cnt;
  logic [1:0] saved_cause;

  // Register 0 is hardwired, so a write to it never creates a dependency.
  logic ex_match, mem_match;
  assign ex_match  = (ex_rd != 5'd0) &&
                     ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
  assign mem_match = (mem_rd != 5'd0) &&
                     ((mem_rd == id_rs) || (id_uses_rt && (mem_rd == id_rt)));

  logic hb_ld, hl, hb_alu, hb_mem, hazard, branch_flush, halt_go;
  logic [1:0] haz_cause;

  assign hb_ld  = id_branch && ex_mem_read && ex_match;
  assign hl     = !id_branch && ex_mem_read && ex_match;
  assign hb_alu = id_branch && ex_reg_write && !ex_mem_read && ex_match;
  assign hb_mem = id_branch && mem_mem_read && mem_match;
  assign hazard = hb_ld || hl || hb_alu || hb_mem;

  always_comb begin
    haz_cause = 2'b00;
    if (hb_ld)       haz_cause = 2'b11;
    else if (hl)     haz_cause = 2'b01;
    else if (hb_alu) haz_cause = 2'b10;
    else if (hb_mem) haz_cause = 2'b11;
  end

  assign branch_flush = (id_branch && branch_taken) || id_jump;
  // Halt is only taken on a clean RUN cycle so no squash or bubble is lost.
  assign halt_go = (state == S_RUN) && !hazard && !branch_flush && halt_req;

  // Mealy in RUN so a hazard bubbles the same cycle it is seen.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    stall_cause = 2'b00;
    case (state)
      S_RUN: begin
        if (hazard) begin
          // branch_taken is computed from stale operands: never flush here.
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_flush  = 1'b1;
          stall_cause = haz_cause;
        end else begin
          ifid_flush  = branch_flush;
        end
      end
      S_STALL: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_flush  = 1'b1;
        stall_cause = saved_cause;
      end
      S_HALT: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_flush  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_RUN;
      stall_cnt   <= 2'd0;
      drain_cnt   <= 3'd0;
      saved_cause <= 2'b00;
      halt_ack    <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (hazard && hb_ld) begin
            // First bubble happens now; one more is spent in STALL.
            state       <= S_STALL;
            stall_cnt   <= 2'd1;
            saved_cause <= haz_cause;
          end else if (halt_go) begin
            state     <= S_HALT;
            drain_cnt <= 3'd0;
            halt_ack  <= 1'b0;
          end
        end
        S_STALL: begin
          stall_cnt <= stall_cnt - 2'd1;
          if (stall_cnt <= 2'd1) state <= S_RUN;
        end
        S_HALT: begin
          if (!halt_req) begin
            state     <= S_RUN;
            drain_cnt <= 3'd0;
            halt_ack  <= 1'b0;
          end else if (drain_cnt != DRAIN_N) begin
            drain_cnt <= drain_cnt + 3'd1;
            if (drain_cnt == DRAIN_LAST) halt_ack <= 1'b1;
          end
        end
        default: state <= S_RUN;
      endcase
    end
  end

`ifdef HAZ_STALL_CNT_EN
  logic counting;
  assign counting = ((state == S_RUN) && hazard) || (state == S_STALL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (counting && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire
